// File: rtl/ahb_pkg.sv
`default_nettype none
//==========================================================================
// ahb_pkg: AHB encodings and arbiter state type.                  Rev 1.0
//==========================================================================
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OWNED  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_bus_arbiter_if.sv
`default_nettype none
//==========================================================================
// ahb_bus_arbiter_if: requester-side and bridge-side arbiter signals. Rev 1.0
//==========================================================================
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  localparam int MID_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]        hbusreq;
  logic [NUM_MASTERS-1:0]        hlock;
  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr;
  logic [NUM_MASTERS*2-1:0]      m_htrans;
  logic [NUM_MASTERS-1:0]        m_hwrite;
  logic [NUM_MASTERS-1:0]        m_hready_in;
  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata;
  logic                          hready_out;
  logic [1:0]                    hresp;

  logic [NUM_MASTERS-1:0]        hgrant;
  logic [MID_W-1:0]              hmaster;
  logic [MID_W-1:0]              hmaster_data;
  logic                          hmastlock;
  logic [ADDR_W-1:0]             haddr;
  logic [1:0]                    htrans;
  logic                          hwrite;
  logic                          hready_in;
  logic [DATA_W-1:0]             hwdata;

  // Arbiter view: takes requests and slave response, drives grant and muxed bus.
  modport slave (
    input  hbusreq, hlock, m_haddr, m_htrans, m_hwrite, m_hready_in, m_hwdata,
           hready_out, hresp,
    output hgrant, hmaster, hmaster_data, hmastlock, haddr, htrans, hwrite,
           hready_in, hwdata
  );

  modport master (
    output hbusreq, hlock, m_haddr, m_htrans, m_hwrite, m_hready_in, m_hwdata,
           hready_out, hresp,
    input  hgrant, hmaster, hmaster_data, hmastlock, haddr, htrans, hwrite,
           hready_in, hwdata
  );

endinterface
`default_nettype wire

// File: rtl/ahb_rr_pick.sv
`default_nettype none
//==========================================================================
// ahb_rr_pick: circular first-requester search from a start index.  Rev 1.0
//==========================================================================
module ahb_rr_pick #(
  parameter int NUM_MASTERS = 2,
  localparam int MID_W = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] skip,
  input  logic [MID_W-1:0]       start,
  output logic                   found,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [MID_W-1:0]       idx
);
  logic [NUM_MASTERS-1:0] cand;

  always_comb begin
    // A skipped master still wins when it is the only one asking.
    cand = req & ~skip;
    if (cand == '0) cand = req;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && cand[(int'(start) + k) % NUM_MASTERS]) begin
        found = 1'b1;
        idx   = MID_W'((int'(start) + k) % NUM_MASTERS);
        grant[(int'(start) + k) % NUM_MASTERS] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
//==========================================================================
// ahb_bus_arbiter: round-robin AHB arbiter with pipelined data-phase owner.
// Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.  Rev 1.0
//==========================================================================
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic               hclk,
  input  logic               hreset,
  ahb_bus_arbiter_if.slave   bus
);
  localparam int MID_W = $clog2(NUM_MASTERS);

  arb_state_e             r_state, w_state_n;
  logic [MID_W-1:0]       r_hmaster, w_hmaster_n;
  logic [MID_W-1:0]       r_hmaster_data;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_n;
  logic                   r_err_pend, w_err_pend_n;
  logic                   w_arb_take;

  logic [1:0]             w_owner_htrans;
  logic                   w_owner_req, w_owner_lock, w_arb_pt, w_keep_lock;
  logic                   w_resp_first;

  logic [MID_W-1:0]       w_start;
  logic [NUM_MASTERS-1:0] w_skip;
  logic                   w_found;
  logic [NUM_MASTERS-1:0] w_pick_grant;
  logic [MID_W-1:0]       w_pick_idx;

  assign w_owner_htrans = bus.m_htrans[int'(r_hmaster)*2 +: 2];
  assign w_owner_req    = bus.hbusreq[r_hmaster];
  assign w_owner_lock   = bus.hlock[r_hmaster];
  assign w_resp_first   = (bus.hresp != HRESP_OKAY) && !bus.hready_out;
  assign w_arb_pt       = bus.hready_out &&
                          ((w_owner_htrans == HTRANS_IDLE) || !w_owner_req ||
                           (r_state == ARB_IDLE));
  // A pending error response cancels the lock so normal arbitration resumes.
  assign w_keep_lock    = w_owner_lock && (w_owner_req || (r_state == ARB_LOCKED)) &&
                          !r_err_pend;

  ahb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req   (bus.hbusreq),
    .skip  (w_skip),
    .start (w_start),
    .found (w_found),
    .grant (w_pick_grant),
    .idx   (w_pick_idx)
  );

`ifdef ARB_FIXED_PRIORITY_EN
  assign w_start = '0;
  assign w_skip  = '0;
`else
  logic [MID_W-1:0]       r_ptr;
  logic [NUM_MASTERS-1:0] r_skip;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_ptr  <= '0;
      r_skip <= '0;
    end else if (bus.hready_out) begin
      if (w_arb_take) begin
        r_skip <= '0;
        if (w_found) r_ptr <= w_pick_idx;
      end
    end else if (w_resp_first && (bus.hresp != HRESP_ERROR)) begin
      r_skip <= r_skip | r_grant;
    end
  end

  // The pointer slot itself is eligible only when the bus is parked.
  assign w_start = (r_state == ARB_IDLE) ? r_ptr :
                   ((r_ptr == MID_W'(NUM_MASTERS-1)) ? '0 : r_ptr + MID_W'(1));
  assign w_skip  = r_skip;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state        <= ARB_IDLE;
      r_hmaster      <= '0;
      r_grant        <= NUM_MASTERS'(1);
      r_hmaster_data <= '0;
      r_err_pend     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_hmaster  <= w_hmaster_n;
      r_grant    <= w_grant_n;
      r_err_pend <= w_err_pend_n;
      if (bus.hready_out) r_hmaster_data <= r_hmaster;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_hmaster_n  = r_hmaster;
    w_grant_n    = r_grant;
    w_err_pend_n = r_err_pend;
    w_arb_take   = 1'b0;
    if (bus.hready_out) begin
      w_err_pend_n = 1'b0;
      if (r_err_pend && (r_state == ARB_LOCKED)) w_state_n = ARB_OWNED;
      if (w_arb_pt) begin
        if (w_keep_lock) begin
          w_state_n = ARB_LOCKED;
        end else begin
          w_arb_take = 1'b1;
          if (w_found) begin
            w_hmaster_n = w_pick_idx;
            w_grant_n   = w_pick_grant;
            w_state_n   = bus.hlock[w_pick_idx] ? ARB_LOCKED : ARB_OWNED;
          end else begin
            w_hmaster_n = '0;
            w_grant_n   = NUM_MASTERS'(1);
            w_state_n   = ARB_IDLE;
          end
        end
      end
    end else if (w_resp_first) begin
      w_err_pend_n = 1'b1;
    end
  end

  assign bus.hgrant       = r_grant;
  assign bus.hmaster      = r_hmaster;
  assign bus.hmaster_data = r_hmaster_data;
  assign bus.hmastlock    = (r_state == ARB_LOCKED);
  assign bus.haddr        = bus.m_haddr[int'(r_hmaster)*ADDR_W +: ADDR_W];
  assign bus.htrans       = (hreset || w_resp_first) ? HTRANS_IDLE : w_owner_htrans;
  assign bus.hwrite       = bus.m_hwrite[r_hmaster];
  assign bus.hready_in    = hreset ? 1'b0 : bus.m_hready_in[r_hmaster];
  assign bus.hwdata       = bus.m_hwdata[int'(r_hmaster_data)*DATA_W +: DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
//==========================================================================
// tb_ahb_bus_arbiter: directed self-checking bench for ahb_bus_arbiter. Rev 1.0
//==========================================================================
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic hclk   = 1'b0;
  logic hreset = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_defaults();
    bus.hbusreq     = '0;
    bus.hlock       = '0;
    bus.m_haddr     = '0;
    bus.m_htrans    = '0;
    bus.m_hwrite    = '0;
    bus.m_hready_in = '0;
    bus.m_hwdata    = '0;
    bus.hready_out  = 1'b1;
    bus.hresp       = HRESP_OKAY;
  endtask

  task automatic do_reset();
    drive_defaults();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    drive_defaults();
    bus.hbusreq     = 2'b11;
    bus.m_htrans    = {HTRANS_NONSEQ, HTRANS_NONSEQ};
    bus.m_hready_in = 2'b11;
    hreset = 1'b1;
    tick();
    n_cmp++; if (bus.htrans !== 2'b00) begin n_err++; $display("FAIL rst_htrans got %b exp 00", bus.htrans); end
    n_cmp++; if (bus.hready_in !== 1'b0) begin n_err++; $display("FAIL rst_hready_in got %b exp 0", bus.hready_in); end
    n_cmp++; if (bus.hgrant !== 2'b01) begin n_err++; $display("FAIL rst_hgrant got %b exp 01", bus.hgrant); end
    n_cmp++; if (bus.hmastlock !== 1'b0) begin n_err++; $display("FAIL rst_hmastlock got %b exp 0", bus.hmastlock); end
    drive_defaults();
    hreset = 1'b0;
    tick();
    n_cmp++; if (bus.hgrant !== 2'b01) begin n_err++; $display("FAIL park_hgrant got %b exp 01", bus.hgrant); end
    n_cmp++; if (bus.hmaster !== 1'b0) begin n_err++; $display("FAIL park_hmaster got %b exp 0", bus.hmaster); end
    n_cmp++; if (bus.htrans !== 2'b00) begin n_err++; $display("FAIL park_htrans got %b exp 00", bus.htrans); end
    n_cmp++; if (bus.hready_in !== 1'b0) begin n_err++; $display("FAIL park_hready_in got %b exp 0", bus.hready_in); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g [4];
    logic [31:0] exp_a [4];
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_a = '{32'h8000_0003, 32'h8000_0001, 32'h8000_0003, 32'h8000_0001};
    do_reset();
    bus.hbusreq  = 2'b11;
    bus.m_htrans = {HTRANS_NONSEQ, HTRANS_NONSEQ};
    bus.m_haddr  = {32'h8000_0003, 32'h8000_0001};
    tick();
    n_cmp++; if (bus.hgrant !== 2'b01) begin n_err++; $display("FAIL rr_first_grant got %b exp 01", bus.hgrant); end
    n_cmp++; if (bus.haddr !== 32'h8000_0001) begin n_err++; $display("FAIL rr_first_addr got %h exp 80000001", bus.haddr); end
    for (int i = 0; i < 4; i++) begin
      bus.m_htrans = {HTRANS_IDLE, HTRANS_IDLE};
      tick();
      n_cmp++; if (bus.hgrant !== exp_g[i]) begin n_err++; $display("FAIL rr_grant[%0d] got %b exp %b", i, bus.hgrant, exp_g[i]); end
      n_cmp++; if (bus.haddr !== exp_a[i]) begin n_err++; $display("FAIL rr_addr[%0d] got %h exp %h", i, bus.haddr, exp_a[i]); end
      bus.m_htrans = {HTRANS_NONSEQ, HTRANS_NONSEQ};
      tick();
      n_cmp++; if (bus.hgrant !== exp_g[i]) begin n_err++; $display("FAIL rr_hold[%0d] got %b exp %b", i, bus.hgrant, exp_g[i]); end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    bus.hbusreq  = 2'b10;
    bus.m_htrans = {HTRANS_NONSEQ, HTRANS_IDLE};
    bus.m_hwrite = 2'b10;
    bus.m_haddr  = {32'h8000_0001, 32'h0000_0000};
    bus.m_hwdata = {32'h8202_0613, 32'hDEAD_BEEF};
    tick();
    n_cmp++; if (bus.hmaster !== 1'b1) begin n_err++; $display("FAIL ws_hmaster got %b exp 1", bus.hmaster); end
    n_cmp++; if (bus.hmaster_data !== 1'b0) begin n_err++; $display("FAIL ws_hmd_lag got %b exp 0", bus.hmaster_data); end
    tick();
    n_cmp++; if (bus.hmaster_data !== 1'b1) begin n_err++; $display("FAIL ws_hmd got %b exp 1", bus.hmaster_data); end
    n_cmp++; if (bus.hwrite !== 1'b1) begin n_err++; $display("FAIL ws_hwrite got %b exp 1", bus.hwrite); end
    n_cmp++; if (bus.haddr !== 32'h8000_0001) begin n_err++; $display("FAIL ws_haddr got %h exp 80000001", bus.haddr); end
    bus.hready_out = 1'b0;
    bus.hbusreq    = 2'b01;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.hmaster_data !== 1'b1) begin n_err++; $display("FAIL ws_hold_hmd[%0d] got %b exp 1", i, bus.hmaster_data); end
      n_cmp++; if (bus.hwdata !== 32'h8202_0613) begin n_err++; $display("FAIL ws_hold_hwdata[%0d] got %h exp 82020613", i, bus.hwdata); end
      n_cmp++; if (bus.hgrant !== 2'b10) begin n_err++; $display("FAIL ws_hold_grant[%0d] got %b exp 10", i, bus.hgrant); end
    end
    bus.hready_out = 1'b1;
    tick();
    n_cmp++; if (bus.hgrant !== 2'b01) begin n_err++; $display("FAIL ws_regrant got %b exp 01", bus.hgrant); end
    n_cmp++; if (bus.hwdata !== 32'h8202_0613) begin n_err++; $display("FAIL ws_last_hwdata got %h exp 82020613", bus.hwdata); end
    tick();
    n_cmp++; if (bus.hwdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ws_next_hwdata got %h exp deadbeef", bus.hwdata); end
  endtask

  task automatic test_lock();
    do_reset();
    bus.hbusreq  = 2'b11;
    bus.hlock    = 2'b01;
    bus.m_htrans = {HTRANS_NONSEQ, HTRANS_NONSEQ};
    tick();
    n_cmp++; if (bus.hmastlock !== 1'b1) begin n_err++; $display("FAIL lk_enter got %b exp 1", bus.hmastlock); end
    bus.m_htrans = {HTRANS_NONSEQ, HTRANS_SEQ};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.hgrant !== 2'b01) begin n_err++; $display("FAIL lk_seq_grant[%0d] got %b exp 01", i, bus.hgrant); end
      n_cmp++; if (bus.hmastlock !== 1'b1) begin n_err++; $display("FAIL lk_seq_lock[%0d] got %b exp 1", i, bus.hmastlock); end
    end
    // An IDLE beat with hlock still high must not release the bus.
    bus.m_htrans = {HTRANS_NONSEQ, HTRANS_IDLE};
    tick();
    n_cmp++; if (bus.hgrant !== 2'b01) begin n_err++; $display("FAIL lk_idle_grant got %b exp 01", bus.hgrant); end
    bus.hlock = 2'b00;
    tick();
    n_cmp++; if (bus.hgrant !== 2'b10) begin n_err++; $display("FAIL lk_release_grant got %b exp 10", bus.hgrant); end
    n_cmp++; if (bus.hmastlock !== 1'b0) begin n_err++; $display("FAIL lk_release_lock got %b exp 0", bus.hmastlock); end
  endtask

  task automatic test_error_resp();
    do_reset();
    bus.hbusreq  = 2'b01;
    bus.hlock    = 2'b01;
    bus.m_htrans = {HTRANS_IDLE, HTRANS_NONSEQ};
    tick();
    bus.m_htrans   = {HTRANS_IDLE, HTRANS_SEQ};
    bus.hresp      = HRESP_ERROR;
    bus.hready_out = 1'b0;
    #1;
    n_cmp++; if (bus.htrans !== 2'b00) begin n_err++; $display("FAIL err_htrans got %b exp 00", bus.htrans); end
    tick();
    n_cmp++; if (bus.hmastlock !== 1'b1) begin n_err++; $display("FAIL err_lock_hold got %b exp 1", bus.hmastlock); end
    bus.hready_out = 1'b1;
    #1;
    n_cmp++; if (bus.htrans !== 2'b11) begin n_err++; $display("FAIL err_htrans_2nd got %b exp 11", bus.htrans); end
    tick();
    bus.hresp = HRESP_OKAY;
    n_cmp++; if (bus.hmastlock !== 1'b0) begin n_err++; $display("FAIL err_unlock got %b exp 0", bus.hmastlock); end
    n_cmp++; if (bus.hgrant !== 2'b01) begin n_err++; $display("FAIL err_grant got %b exp 01", bus.hgrant); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.hbusreq  = 2'b10;
    bus.m_htrans = {HTRANS_NONSEQ, HTRANS_IDLE};
    tick();
    bus.m_htrans = {HTRANS_SEQ, HTRANS_IDLE};
    tick();
    n_cmp++; if (bus.hmaster_data !== 1'b1) begin n_err++; $display("FAIL mb_hmd got %b exp 1", bus.hmaster_data); end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    n_cmp++; if (bus.hgrant !== 2'b01) begin n_err++; $display("FAIL mb_grant got %b exp 01", bus.hgrant); end
    n_cmp++; if (bus.hmaster !== 1'b0) begin n_err++; $display("FAIL mb_hmaster got %b exp 0", bus.hmaster); end
    n_cmp++; if (bus.hmaster_data !== 1'b0) begin n_err++; $display("FAIL mb_hmd_rst got %b exp 0", bus.hmaster_data); end
  endtask

  initial begin
    drive_defaults();
    test_reset();
    test_round_robin();
    test_wait_states();
    test_lock();
    test_error_resp();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Shares the single AHB master port of the AHB-to-APB bridge between NUM_MASTERS requesters (CPU-side master, DMA, test master).
- Grants the address phase round-robin and tracks data-phase ownership one transfer behind, following the AHB pipeline.
- Muxes the granted master's address/control and the data-phase owner's hwdata onto the bridge's slave-side inputs.
- Sits between the ahb_master instances and the AHB slave/bridge.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, write-data width.
- MID_W, $clog2(NUM_MASTERS), master-index width (derived, not overridable).

Ports:
- hclk  in  1  bus clock; all state on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hbusreq  in  NUM_MASTERS  per-master bus request.
- hlock  in  NUM_MASTERS  per-master locked-sequence request.
- m_haddr  in  NUM_MASTERS*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W].
- m_htrans  in  NUM_MASTERS*2  per-master transfer type.
- m_hwrite  in  NUM_MASTERS  per-master write flag.
- m_hready_in  in  NUM_MASTERS  per-master transfer-valid qualifier.
- m_hwdata  in  NUM_MASTERS*DATA_W  per-master write data.
- hready_out  in  1  slave ready; transfer completes when high.
- hresp  in  2  slave response.
- hgrant  out  NUM_MASTERS  one-hot address-phase grant.
- hmaster  out  MID_W  index of the address-phase owner.
- hmaster_data  out  MID_W  index of the data-phase owner.
- hmastlock  out  1  current address phase is part of a locked sequence.
- haddr  out  ADDR_W  muxed address.
- htrans  out  2  muxed transfer type.
- hwrite  out  1  muxed write flag.
- hready_in  out  1  muxed transfer-valid qualifier.
- hwdata  out  DATA_W  write data muxed by hmaster_data.

Behaviour:
- Reset (hreset=1 at a hclk edge): hgrant=1 (master 0 default), hmaster=0, hmaster_data=0, hmastlock=0, rr pointer=0, state=IDLE.
- Outputs during reset follow the master-0 mux: htrans forced 2'b00, hready_in forced 0.
- Mux outputs are combinational from registered hmaster and hmaster_data. No added latency.
- FSM states:
  - IDLE: no request. Master 0 is parked and owns the bus.
  - OWNED: a requesting master owns the bus.
  - LOCKED: the owner holds the bus through a locked sequence.
- Arbitration point: an edge with hready_out=1 and any of:
  - owner htrans==IDLE(00);
  - owner hbusreq==0;
  - state==IDLE.
  BUSY (01) and SEQ (11) never end ownership.
- At an arbitration point:
  - New owner is the first requester after the rr pointer, searching circularly.
  - hgrant and hmaster update on that edge. The pointer moves to the new owner.
  - No requester → IDLE, grant parks on master 0.
  - Same master re-requesting with others pending loses priority to the next requester.
- Data phase: on every edge with hready_out=1, hmaster_data<=hmaster. When hready_out=0, hmaster_data, hgrant and hmaster all hold (wait states freeze the pipeline).
- Locking:
  - The owner asserting hlock at an arbitration point enters LOCKED, and hmastlock=1 for its address phases.
  - LOCKED exits only when hlock deasserts and an arbitration point occurs.
- hresp:
  - ERROR (01), RETRY (10) or SPLIT (11) with hready_out=0 (first response cycle) forces output htrans=IDLE for that cycle.
  - On the following completing edge, LOCKED drops to OWNED and normal arbitration resumes.
  - The owner does not otherwise lose its grant on ERROR. On RETRY or SPLIT, the owner is skipped for one arbitration round.
- Simultaneous requests at reset release: master 0 wins (pointer starts at 0, search includes the pointer position when idle).
- Reset mid-transfer: all state returns to reset values on that edge. There is no transfer-completion obligation.

Optional Feature:
- ARB_FIXED_PRIORITY_EN defined: the lowest-index requester always wins at an arbitration point. The rr pointer and the RETRY/SPLIT skip are removed.
- Undefined: round-robin as specified above.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ = 2'b00/01/10/11;
  - HRESP_OKAY/ERROR/RETRY/SPLIT = 2'b00/01/10/11;
  - arbiter state enum.
- Sub-module ahb_rr_pick: combinational next-owner search from the request vector, pointer and skip mask, returning a one-hot grant and an index.

Test Plan:
1. Reset, then hbusreq=2'b00 → hgrant=2'b01, hmaster=0, htrans=00, hready_in=0.
2. hbusreq=2'b11, both htrans=NONSEQ, hready_out=1 → grants alternate 0,1,0,1 on successive IDLE-terminated transfers; haddr alternates 32'h8000_0001 / 32'h8000_0003.
3. Master 1 write to 32'h8000_0001 with hwdata=32'h8202_0613, hready_out=0 for 2 cycles → hmaster_data holds at 1; hwdata=32'h8202_0613 is held until hready_out=1.
4. Master 0 hlock=1 plus 3 SEQ beats while master 1 requests → hgrant stays 2'b01 and hmastlock=1 until hlock drops, then grant goes to 2'b10.
5. hresp=ERROR with hready_out=0 → output htrans=00 that cycle; LOCKED exits on the next hready_out=1.
6. Assert hreset mid-burst of master 1 → the next edge shows hgrant=2'b01 and hmaster=hmaster_data=0.
